// File: rtl/alu_pkg.sv
// Shared types and constants for the two-beat ALU engine: op encoding and FSM state.
// Used by the RTL and by the checker and stimulus code.
// Build option ALU_ENGINE_SAT_EN is consumed by alu_datapath, not here.
package alu_pkg;

  // {op[1], op[0]}: op[0] arrives with operand A, op[1] with operand B
  typedef logic [1:0] op_t;

  localparam op_t OP_ADD  = 2'b00;
  localparam op_t OP_SUB  = 2'b01;
  localparam op_t OP_XOR  = 2'b10;
  localparam op_t OP_XNOR = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_OPB     = 2'd1;
  localparam state_t ST_COMPUTE = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU: (a, b, op) -> {overflow, result}; add/sub carry-borrow at DATA_WIDTH+1 bits.
// Latency: none (pure combinational). Backpressure: none.
// ALU_ENGINE_SAT_EN: add saturates to all-ones on carry, sub to zero on borrow.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  op_t                   op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;

  // Top bit of the widened difference is the unsigned borrow (set iff a < b)
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        overflow = sum[DATA_WIDTH];
`ifdef ALU_ENGINE_SAT_EN
        result   = sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
`else
        result   = sum[DATA_WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        overflow = diff[DATA_WIDTH];
`ifdef ALU_ENGINE_SAT_EN
        result   = diff[DATA_WIDTH] ? '0 : diff[DATA_WIDTH-1:0];
`else
        result   = diff[DATA_WIDTH-1:0];
`endif
      end
      OP_XOR: begin
        result   = a ^ b;
        overflow = 1'b0;
      end
      OP_XNOR: begin
        result   = ~(a ^ b);
        overflow = 1'b0;
      end
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_engine.sv
// Two-beat ALU engine: beat 1 = A + op[0], beat 2 = B + op[1]; registered result with one-cycle done pulse.
// Latency: done is high in the cycle after the edge following the B capture edge.
// Backpressure: none; beats arriving in COMPUTE/DONE are dropped. Optional ALU_ENGINE_SAT_EN saturates add/sub.
module alu_engine
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  opcode_valid,
  input  logic                  opcode,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  done
);

  state_t                state;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  op_t                   op_q;
  logic [DATA_WIDTH-1:0] dp_result;
  logic                  dp_overflow;

  alu_datapath #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_datapath (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result   (dp_result),
    .overflow (dp_overflow)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      // done mirrors the DONE state, registered on the same edge that enters it
      done <= (state == ST_COMPUTE);
      case (state)
        ST_IDLE: begin
          if (opcode_valid) begin
            a_q     <= data;
            op_q[0] <= opcode;
            state   <= ST_OPB;
          end
        end
        ST_OPB: begin
          if (opcode_valid) begin
            b_q     <= data;
            op_q[1] <= opcode;
            state   <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          result   <= dp_result;
          overflow <= dp_overflow;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_engine.sv
// Scoreboard bench for alu_engine: directed scenarios then random ops, checked by a decoupled monitor.
// Honours ALU_ENGINE_SAT_EN for both directed expectations and the reference model.
module tb_alu_engine;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       opcode_valid = 1'b0;
  logic       opcode = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] result;
  logic       overflow;
  logic       done;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t       expq[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] last_res = 8'h00;
  logic       last_ovf = 1'b0;
  bit         hold_pending = 1'b0;

  alu_engine #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .opcode_valid (opcode_valid),
    .opcode       (opcode),
    .data         (data),
    .result       (result),
    .overflow     (overflow),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned operand values
  function automatic void model(input op_t op, input int a, input int b,
                                output logic [7:0] r, output logic o);
    int s;
    bit sat;
`ifdef ALU_ENGINE_SAT_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    r = 8'h00;
    o = 1'b0;
    case (op)
      OP_ADD: begin
        s = a + b;
        o = (s > 255);
        r = (o && sat) ? 8'hFF : 8'(s % 256);
      end
      OP_SUB: begin
        s = a - b + 256;
        o = (a < b);
        r = (o && sat) ? 8'h00 : 8'(s % 256);
      end
      OP_XOR:  r = 8'(a ^ b);
      default: r = 8'(~(a ^ b));
    endcase
  endfunction

  // Issue one op: A beat, gap idle cycles, B beat, then two cycles covering COMPUTE and DONE
  task automatic run_op(input op_t op, input logic [7:0] a, input logic [7:0] b, input int gap,
                        input bit junk, input logic [7:0] exp_res, input logic exp_ovf);
    exp_t e;
    @(negedge clk);
    opcode_valid = 1'b1;
    opcode       = op[0];
    data         = a;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      opcode_valid = 1'b0;
      opcode       = 1'($urandom_range(0, 1));
      data         = 8'($urandom);
    end
    @(negedge clk);
    opcode_valid = 1'b1;
    opcode       = op[1];
    data         = b;
    e.res = exp_res;
    e.ovf = exp_ovf;
    e.cyc = cyc + 2;
    expq.push_back(e);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      opcode_valid = junk;
      opcode       = 1'($urandom_range(0, 1));
      data         = 8'($urandom);
    end
    @(negedge clk);
    opcode_valid = 1'b0;
  endtask

  task automatic run_model(input op_t op, input logic [7:0] a, input logic [7:0] b,
                           input int gap, input bit junk);
    logic [7:0] r;
    logic       o;
    model(op, int'(a), int'(b), r, o);
    run_op(op, a, b, gap, junk, r, o);
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks hold after it falls
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: done=1 with no pending op (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("result", int'(result), int'(e.res));
          check("overflow", int'(overflow), int'(e.ovf));
          check("done_cycle", cyc, e.cyc);
          last_res     = e.res;
          last_ovf     = e.ovf;
          hold_pending = 1'b1;
        end
      end else if (hold_pending) begin
        check("hold_result", int'(result), int'(last_res));
        check("hold_overflow", int'(overflow), int'(last_ovf));
        hold_pending = 1'b0;
      end
    end
  end

  initial begin
    int wait_cyc;
    #2;
    check("reset_result", int'(result), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_done", int'(done), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

`ifdef ALU_ENGINE_SAT_EN
    run_op(OP_ADD,  8'h05, 8'h03, 0, 1'b0, 8'h08, 1'b0);
    run_op(OP_ADD,  8'hFF, 8'h01, 0, 1'b0, 8'hFF, 1'b1);
    run_op(OP_SUB,  8'h03, 8'h05, 0, 1'b0, 8'h00, 1'b1);
`else
    run_op(OP_ADD,  8'h05, 8'h03, 0, 1'b0, 8'h08, 1'b0);
    run_op(OP_ADD,  8'hFF, 8'h01, 0, 1'b0, 8'h00, 1'b1);
    run_op(OP_SUB,  8'h03, 8'h05, 0, 1'b0, 8'hFE, 1'b1);
`endif
    run_op(OP_SUB,  8'h09, 8'h04, 0, 1'b0, 8'h05, 1'b0);
    run_op(OP_XOR,  8'hA5, 8'h0F, 0, 1'b0, 8'hAA, 1'b0);
    run_op(OP_XNOR, 8'hA5, 8'h0F, 0, 1'b0, 8'h55, 1'b0);
    run_op(OP_ADD,  8'h21, 8'h12, 3, 1'b0, 8'h33, 1'b0);
    // Junk beats land in COMPUTE and DONE; the next op must use only its own operands
    run_op(OP_XOR,  8'h3C, 8'hFF, 0, 1'b1, 8'hC3, 1'b0);
    run_op(OP_ADD,  8'h40, 8'h01, 0, 1'b0, 8'h41, 1'b0);

    // Reset after the A beat only
    @(negedge clk);
    opcode_valid = 1'b1;
    opcode       = 1'b0;
    data         = 8'h10;
    @(negedge clk);
    opcode_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_result", int'(result), 0);
    check("midreset_overflow", int'(overflow), 0);
    check("midreset_done", int'(done), 0);
    hold_pending = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_op(OP_ADD, 8'h02, 8'h03, 0, 1'b0, 8'h05, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_model(op_t'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    wait_cyc = 0;
    while (expq.size() != 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d ops pending, expected 0", expq.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_engine.md
ALU_ENGINE -- requirements
Module: alu_engine

Interface
REQ-001 Parameter: DATA_WIDTH, 8, operand/result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 opcode_valid  input  1  high for one cycle per operand beat; qualifies opcode and data.
REQ-005 opcode  input  1  one opcode bit per beat: first beat = op[0], second beat = op[1].
REQ-006 data  input  DATA_WIDTH  operand: first beat = A, second beat = B.
REQ-007 result  output  DATA_WIDTH  registered result, valid when done=1.
REQ-008 overflow  output  1  registered overflow/borrow flag, valid when done=1.
REQ-009 done  output  1  one-cycle completion pulse.

Function
REQ-010 The FSM SHALL have the states IDLE, OPB, COMPUTE and DONE.
- IDLE->OPB on opcode_valid, capturing A and op[0].
- OPB->COMPUTE on opcode_valid, capturing B and op[1].
- COMPUTE->DONE unconditionally.
- DONE->IDLE unconditionally.
REQ-011 The engine SHALL wait indefinitely in IDLE and in OPB while opcode_valid=0. Any number of idle cycles between beats is legal.
REQ-012 The engine SHALL ignore opcode_valid while in COMPUTE or DONE. A beat arriving in DONE is dropped, not treated as A.
REQ-013 Op encoding {op[1],op[0]}: 00 add, 01 sub, 10 xor, 11 xnor.
REQ-014 Add SHALL compute the 9-bit sum A+B. result = sum[7:0], overflow = carry out.
REQ-015 Sub SHALL compute A-B modulo 2^8 into result, with overflow=1 iff A<B (unsigned borrow).
REQ-016 For xor and xnor, result SHALL be the bitwise A^B or ~(A^B), and overflow SHALL be 0.
REQ-017 Result and overflow SHALL be registered on the COMPUTE->DONE edge. done SHALL be 1 exactly during DONE, i.e. the 2nd rising edge after the B capture edge.
REQ-018 result and overflow SHALL hold their values after done falls, until the next DONE or a reset.
REQ-019 Widths SHALL scale with DATA_WIDTH. The carry/borrow is computed at DATA_WIDTH+1 bits.

Reset
REQ-020 On reset_n=0, regardless of the clock, the engine SHALL immediately force:
- state = IDLE
- result = 0
- overflow = 0
- done = 0
- captured A, B and op = 0
REQ-021 On reset mid-operation, any partial capture SHALL be discarded. The first opcode_valid after reset release SHALL be taken as operand A.

Configuration
REQ-022 With macro ALU_ENGINE_SAT_EN defined, add and sub SHALL saturate:
- add with carry -> result all-ones
- sub with borrow -> result 0
- overflow SHALL still report the carry/borrow.
REQ-023 Without ALU_ENGINE_SAT_EN, add and sub SHALL wrap modulo 2^DATA_WIDTH, per REQ-014 and REQ-015.

Structure
REQ-024 Shared package alu_pkg SHALL hold:
- the 2-bit op typedef
- the constants OP_ADD, OP_SUB, OP_XOR and OP_XNOR
- the FSM state typedef
Checker and stimulus code SHALL reuse this package.
REQ-025 One combinational sub-module, alu_datapath, SHALL map (A, B, op) to {overflow, result}, including saturation. FSM and registers SHALL live in alu_engine.

Verification
REQ-026 The bench SHALL cover these directed scenarios (clock edges counted from the B capture edge):
- Add: A=0x05/op0=0, B=0x03/op1=0 -> done at 2nd edge, result=0x08, overflow=0.
- Add carry: 0xFF + 0x01 -> result=0x00, overflow=1. With SAT_EN: result=0xFF, overflow=1.
- Sub borrow: A=0x03/op0=1, B=0x05/op1=0 -> result=0xFE, overflow=1. With SAT_EN: result=0x00.
- Logic: xor 0xA5,0x0F -> 0xAA, overflow=0. xnor 0xA5,0x0F -> 0x55, overflow=0.
- Gaps and ignored beats: 3 idle cycles between beats -> correct result. A beat during COMPUTE/DONE is ignored, and the next op still computes from its own A/B.
- Reset mid-op: reset_n low after A=0x10 -> outputs 0 at once. Then 0x02 + 0x03 after release -> result=0x05.
